// File: rtl/seg_seq_pkg.sv
// Shared types and pattern constants for the segment chase sequencer.
// The optional bounce mode is enabled with SEG_SEQ_PINGPONG_EN.
package seg_seq_pkg;

    localparam int SEG_IDX_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_ISSUE
    } state_t;

    typedef enum logic [1:0] {
        PAT_FIG8,
        PAT_CIRCLE,
        PAT_VERT,
        PAT_SWEEP
    } pat_t;

    localparam logic [3:0] PAT_LEN_FIG8   = 4'd8;
    localparam logic [3:0] PAT_LEN_CIRCLE = 4'd6;
    localparam logic [3:0] PAT_LEN_VERT   = 4'd4;
    localparam logic [3:0] PAT_LEN_SWEEP  = 4'd7;

    function automatic logic [3:0] pat_len(input logic [1:0] p);
        unique case (pat_t'(p))
            PAT_FIG8:   return PAT_LEN_FIG8;
            PAT_CIRCLE: return PAT_LEN_CIRCLE;
            PAT_VERT:   return PAT_LEN_VERT;
            PAT_SWEEP:  return PAT_LEN_SWEEP;
        endcase
    endfunction

endpackage

// File: rtl/seg_pattern_rom.sv
// Combinational pattern table: (pattern, index) -> (segment, length).
// Unused table slots read back as segment 0.
module seg_pattern_rom
    import seg_seq_pkg::*;
(
    input  logic [1:0]           pat,
    input  logic [2:0]           idx,
    output logic [SEG_IDX_W-1:0] seg,
    output logic [3:0]           len
);

    typedef logic [SEG_IDX_W-1:0] tab_t [8];

    localparam tab_t FIG8   = '{3'd0, 3'd1, 3'd6, 3'd4, 3'd3, 3'd2, 3'd6, 3'd5};
    localparam tab_t CIRCLE = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0};
    localparam tab_t VERT   = '{3'd0, 3'd6, 3'd3, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0};
    localparam tab_t SWEEP  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};

    always_comb begin
        len = pat_len(pat);
        unique case (pat_t'(pat))
            PAT_FIG8:   seg = FIG8[idx];
            PAT_CIRCLE: seg = CIRCLE[idx];
            PAT_VERT:   seg = VERT[idx];
            PAT_SWEEP:  seg = SWEEP[idx];
        endcase
    end

endmodule

// File: rtl/seg_chase_sequencer.sv
// Paces chase steps with a prescaler and issues one segment per step.
// Define SEG_SEQ_PINGPONG_EN to add the pingpong (bounce at ends) input.
module seg_chase_sequencer
    import seg_seq_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           speed,
    input  logic                 direction,
    input  logic [1:0]           pattern_sel,
`ifdef SEG_SEQ_PINGPONG_EN
    input  logic                 pingpong,
`endif
    output logic                 trig_valid,
    output logic [SEG_IDX_W-1:0] trig_seg,
    input  logic                 trig_ready,
    output logic [2:0]           step_idx,
    output logic                 running
);

    localparam int LOW_W = PRESCALE_WIDTH - 3;

    state_t                    state;
    logic [PRESCALE_WIDTH-1:0] counter;
    logic [PRESCALE_WIDTH-1:0] limit;
    logic [2:0]                idx;
    logic [1:0]                pat_cur;
    logic                      dir_r;

    logic [SEG_IDX_W-1:0] rom_seg;
    logic [3:0]           rom_len;
    logic [3:0]           new_len;
    logic [2:0]           idx_next;
    logic                 dir_hold;
    logic                 dir_adv;
    logic                 bounce;
    logic                 at_top;
    logic                 hs;

    assign limit   = {~speed, {LOW_W{1'b1}}};
    assign new_len = pat_len(pattern_sel);
    assign at_top  = (idx == 3'(rom_len - 4'd1));
    assign hs      = (state == S_ISSUE) && trig_valid && trig_ready;

`ifdef SEG_SEQ_PINGPONG_EN
    assign bounce = pingpong;
`else
    assign bounce = 1'b0;
`endif

    seg_pattern_rom u_rom (
        .pat (pat_cur),
        .idx (idx),
        .seg (rom_seg),
        .len (rom_len)
    );

    // While bouncing, direction is owned by the sequencer, not the switch.
    assign dir_hold = bounce ? dir_r : direction;

    always_comb begin
        idx_next = idx;
        dir_adv  = dir_hold;
        if (pattern_sel != pat_cur) begin
            idx_next = dir_r ? 3'd0 : 3'(new_len - 4'd1);
        end else if (dir_r) begin
            if (!at_top) begin
                idx_next = idx + 3'd1;
            end else if (bounce) begin
                dir_adv  = 1'b0;
                idx_next = 3'(rom_len - 4'd2);
            end else begin
                idx_next = 3'd0;
            end
        end else begin
            if (idx != 3'd0) begin
                idx_next = idx - 3'd1;
            end else if (bounce) begin
                dir_adv  = 1'b1;
                idx_next = 3'd1;
            end else begin
                idx_next = 3'(rom_len - 4'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            counter    <= '0;
            idx        <= '0;
            pat_cur    <= '0;
            dir_r      <= 1'b0;
            trig_valid <= 1'b0;
            trig_seg   <= '0;
        end else begin
            dir_r <= hs ? dir_adv : dir_hold;
            case (state)
                S_IDLE: begin
                    counter <= '0;
                    if (enable) state <= S_COUNT;
                end
                S_COUNT: begin
                    if (!enable) begin
                        state   <= S_IDLE;
                        counter <= '0;
                    end else if (counter >= limit) begin
                        counter    <= '0;
                        trig_seg   <= rom_seg;
                        trig_valid <= 1'b1;
                        state      <= S_ISSUE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                S_ISSUE: begin
                    counter <= '0;
                    if (hs) begin
                        trig_valid <= 1'b0;
                        idx        <= idx_next;
                        pat_cur    <= pattern_sel;
                        state      <= enable ? S_COUNT : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign step_idx = idx;
    assign running  = (state != S_IDLE);

endmodule

// File: tb/tb_seg_chase_sequencer.sv
// Self-checking bench: cycle model of the chase rules plus directed literals.
// Exercises the bounce mode too when SEG_SEQ_PINGPONG_EN is defined.
module tb_seg_chase_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] speed = 3'd7;
    logic       direction = 1'b1;
    logic [1:0] pattern_sel = 2'd0;
    logic       trig_ready = 1'b1;
    logic       pp = 1'b0;
    logic       trig_valid;
    logic [2:0] trig_seg;
    logic [2:0] step_idx;
    logic       running;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    int tab [4][8] = '{'{0, 1, 6, 4, 3, 2, 6, 5},
                       '{0, 1, 2, 3, 4, 5, 0, 0},
                       '{0, 6, 3, 6, 0, 0, 0, 0},
                       '{0, 1, 2, 3, 4, 5, 6, 0}};
    int lens [4] = '{8, 6, 4, 7};

    int m_run = 0, m_pend = 0, m_cnt = 0, m_idx = 0;
    int m_pat = 0, m_dir = 0, m_seg = 0;
    int lim, nd, len_c, bnc;

    int acc_seg[$];
    int acc_idx[$];
    int acc_t[$];

    seg_chase_sequencer #(.PRESCALE_WIDTH(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .speed       (speed),
        .direction   (direction),
        .pattern_sel (pattern_sel),
`ifdef SEG_SEQ_PINGPONG_EN
        .pingpong    (pp),
`endif
        .trig_valid  (trig_valid),
        .trig_seg    (trig_seg),
        .trig_ready  (trig_ready),
        .step_idx    (step_idx),
        .running     (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: step timing from the limit formula, tables by plain lookup.
    initial forever begin
        @(posedge clk);
        cyc++;
        lim = (7 - int'(speed)) * 8 + 7;
`ifdef SEG_SEQ_PINGPONG_EN
        bnc = int'(pp);
`else
        bnc = 0;
`endif
        if (reset) begin
            m_run = 0; m_pend = 0; m_cnt = 0; m_idx = 0;
            m_pat = 0; m_dir = 0; m_seg = 0;
        end else begin
            nd = bnc ? m_dir : int'(direction);
            if (m_run == 0) begin
                if (enable) m_run = 1;
            end else if (m_pend == 0) begin
                if (!enable) begin
                    m_run = 0; m_cnt = 0;
                end else if (m_cnt >= lim) begin
                    m_cnt = 0; m_pend = 1; m_seg = tab[m_pat][m_idx];
                end else begin
                    m_cnt++;
                end
            end else if (trig_ready) begin
                m_pend = 0;
                m_run = int'(enable);
                len_c = lens[m_pat];
                if (int'(pattern_sel) != m_pat) begin
                    m_pat = int'(pattern_sel);
                    m_idx = m_dir ? 0 : lens[m_pat] - 1;
                end else if (m_dir != 0) begin
                    if (m_idx < len_c - 1) m_idx++;
                    else if (bnc != 0) begin nd = 0; m_idx = len_c - 2; end
                    else m_idx = 0;
                end else begin
                    if (m_idx > 0) m_idx--;
                    else if (bnc != 0) begin nd = 1; m_idx = 1; end
                    else m_idx = len_c - 1;
                end
            end
            m_dir = nd;
        end
    end

    initial forever begin
        @(negedge clk);
        check("outputs{valid,seg,idx,run}",
              int'({trig_valid, trig_seg, step_idx, running}),
              (m_pend << 7) | (m_seg << 4) | (m_idx << 1) | (m_run != 0 ? 1 : 0));
        if (!reset && trig_valid && trig_ready) begin
            acc_seg.push_back(int'(trig_seg));
            acc_idx.push_back(int'(step_idx));
            acc_t.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_q();
        acc_seg.delete();
        acc_idx.delete();
        acc_t.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        clear_q();
    endtask

    task automatic wait_acc(input int n, input int budget, input string name);
        int k = 0;
        while (acc_seg.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check(name, acc_seg.size(), n);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int k = 0;
        while (!trig_valid && k < budget) begin
            tick(1);
            k++;
        end
        check(name, int'(trig_valid), 1);
    endtask

    initial begin
        int exp_a [9] = '{0, 1, 6, 4, 3, 2, 6, 5, 0};
        int exp_bs [5] = '{0, 5, 6, 2, 3};
        int exp_bi [5] = '{0, 7, 6, 5, 4};
        int exp_d [9] = '{0, 1, 6, 4, 0, 6, 3, 6, 0};
        int n0;

        tick(2);
        check("reset_state", int'({trig_valid, trig_seg, step_idx, running}), 0);

        enable = 1'b1; direction = 1'b1; speed = 3'd7;
        pattern_sel = 2'd0; trig_ready = 1'b1;
        do_reset();
        wait_acc(9, 120, "A_count");
        for (int i = 0; i < 9; i++) check("A_seg", acc_seg[i], exp_a[i]);
        for (int i = 1; i < 9; i++) check("A_period", acc_t[i] - acc_t[i-1], 9);

        direction = 1'b0;
        do_reset();
        wait_acc(5, 80, "B_count");
        for (int i = 0; i < 5; i++) begin
            check("B_seg", acc_seg[i], exp_bs[i]);
            check("B_idx", acc_idx[i], exp_bi[i]);
        end

        direction = 1'b1; speed = 3'd0; trig_ready = 1'b0;
        do_reset();
        wait_valid(100, "C_valid_rise");
        check("C_first_seg", int'(trig_seg), 0);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("C_hold", int'({trig_valid, trig_seg}), 8);
        end
        trig_ready = 1'b1;
        wait_acc(2, 200, "C_count");
        check("C_gap", acc_t[1] - acc_t[0], 65);

        speed = 3'd7; pattern_sel = 2'd0;
        do_reset();
        wait_acc(3, 60, "D_pre");
        pattern_sel = 2'd2;
        wait_acc(9, 120, "D_count");
        for (int i = 0; i < 9; i++) check("D_seg", acc_seg[i], exp_d[i]);

        trig_ready = 1'b0;
        wait_valid(40, "E_valid_rise");
        check("E_seg", int'(trig_seg), 6);
        enable = 1'b0;
        tick(5);
        check("E_valid_held", int'(trig_valid), 1);
        trig_ready = 1'b1;
        tick(3);
        check("E_stopped", int'({trig_valid, running}), 0);
        n0 = acc_seg.size();
        tick(40);
        check("E_no_trig", acc_seg.size(), n0);
        enable = 1'b1;
        wait_acc(n0 + 1, 40, "E_resume");
        check("E_resume_seg", acc_seg[n0], 3);
        check("E_resume_idx", acc_idx[n0], 2);

`ifdef SEG_SEQ_PINGPONG_EN
        begin
            int exp_p [8] = '{0, 6, 3, 6, 3, 6, 0, 6};
            direction = 1'b1; pattern_sel = 2'd2; pp = 1'b0;
            do_reset();
            tick(1);
            pp = 1'b1;
            wait_acc(9, 120, "P_count");
            for (int i = 0; i < 8; i++) check("P_seg", acc_seg[i+1], exp_p[i]);
            pp = 1'b0;
        end
`endif

        speed = 3'd0; pattern_sel = 2'd0;
        do_reset();
        tick(10);
        reset = 1'b1;
        tick(1);
        check("R_midcount", int'({trig_valid, trig_seg, step_idx, running}), 0);
        reset = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) speed = 3'($urandom_range(0, 7));
            else if ($urandom_range(0, 3) == 0) speed = 3'($urandom_range(5, 7));
            if ($urandom_range(0, 31) == 0) direction = ~direction;
            if ($urandom_range(0, 63) == 0) pattern_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) pp = ~pp;
            trig_ready = ($urandom_range(0, 3) != 0);
            tick(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
